axisprbscheck: RTL and testbench

- AXI-stream slave that consumes the 32-bit pseudorandom stream produced by the codebase's stream PRBS generator and checks it word by word.
- Self-synchronising: seeds its predictor from the received data, declares lock after a run of correct predictions, then counts errors.
- Sits directly downstream of the generator, or at the far end of any loopback path under test (FIFO, DMA, serial link). Provides lock, error and beat statistics for bring-up and BIST.

---
 rtl/axis_prbs_pkg.sv | 20 ++
 rtl/axisprbs_counter.sv | 21 ++
 rtl/axisprbscheck.sv | 123 ++++++++++++
 tb/tb_axisprbscheck.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_prbs_pkg.sv
// Shared PRBS definitions for the stream generator and checker.
// Both ends import this package, so they use the same polynomial and state encoding.
package axis_prbs_pkg;

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] PRBS_POLY = 32'h0000_4002;
  localparam logic [DW-1:0] PRBS_FILL = 32'h8000_0000;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next PRBS word: feedback bit enters at the MSB and the word shifts right.
  function automatic logic [DW-1:0] prbs_next(input logic [DW-1:0] d);
    return {^(d & PRBS_POLY), d[DW-1:1]};
  endfunction

endpackage

// File: rtl/axisprbs_counter.sv
// Saturating statistics counter with synchronous clear.
// Clear takes priority over increment.
module axisprbs_counter #(
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            clr,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNTW'(1);
    end
  end

endmodule

// File: rtl/axisprbscheck.sv
// AXI-stream PRBS checker: seeds from received data, locks after a run of
// correct predictions, then counts beats and errors.
module axisprbscheck
  import axis_prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 8,
  parameter int unsigned CNTW         = 32
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESET,
  input  logic            S_AXIS_TVALID,
  output logic            S_AXIS_TREADY,
  input  logic [DW-1:0]   S_AXIS_TDATA,
  input  logic            i_hold,
  input  logic            i_clear,
  output logic            o_locked,
  output logic            o_err,
  output logic            o_err_seen,
  output logic [CNTW-1:0] o_beats,
  output logic [CNTW-1:0] o_errors
);

  localparam int unsigned MW = 4;
  localparam int unsigned EW = 8;
  localparam logic [MW-1:0] MCNT_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0] ECNT_LAST = EW'(UNLOCK_COUNT - 1);

  state_t        state;
  logic [DW-1:0] exp_word;
  logic [MW-1:0] mcnt;
  logic [EW-1:0] ecnt;

  logic beat;
  logic match;
  logic seed_ok;
  logic beat_locked;
  logic err_beat;

  assign S_AXIS_TREADY = !i_hold && !S_AXI_ARESET;
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign match         = (S_AXIS_TDATA == exp_word);
  assign seed_ok       = (S_AXIS_TDATA != '0);
  assign beat_locked   = beat && (state == LOCKED);
  assign err_beat      = beat_locked && !match;
  assign o_locked      = (state == LOCKED);

  // FSM and predictor; state only advances on accepted beats.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state      <= SEARCH;
      exp_word   <= '0;
      mcnt       <= '0;
      ecnt       <= '0;
      o_err      <= 1'b0;
      o_err_seen <= 1'b0;
    end else begin
      o_err <= err_beat;
      if (i_clear) begin
        o_err_seen <= 1'b0;
      end else if (err_beat) begin
        o_err_seen <= 1'b1;
      end
      if (beat) begin
        unique case (state)
          SEARCH: begin
            // An all-zero word cannot seed the LFSR, so it is ignored.
            if (seed_ok) begin
              exp_word <= prbs_next(S_AXIS_TDATA);
              mcnt     <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              exp_word <= prbs_next(exp_word);
              mcnt     <= mcnt + MW'(1);
              if (mcnt == MCNT_LAST) begin
                ecnt  <= '0;
                state <= LOCKED;
              end
            end else if (seed_ok) begin
              exp_word <= prbs_next(S_AXIS_TDATA);
              mcnt     <= '0;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // Predictor free-runs so an isolated bit error does not propagate.
            exp_word <= prbs_next(exp_word);
            if (match) begin
              ecnt <= '0;
            end else begin
              ecnt <= ecnt + EW'(1);
              if (ecnt == ECNT_LAST) begin
                state <= SEARCH;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  axisprbs_counter #(.CNTW(CNTW)) u_beats (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .inc   (beat_locked),
    .clr   (i_clear),
    .count (o_beats)
  );

  axisprbs_counter #(.CNTW(CNTW)) u_errors (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .inc   (err_beat),
    .clr   (i_clear),
    .count (o_errors)
  );

endmodule

// File: tb/tb_axisprbscheck.sv
// Scoreboard bench for axisprbscheck: per-beat o_err/o_locked expectations are
// queued when stimulus is driven and compared after the clock edge.
module tb_axisprbscheck;

  logic        clk;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        hold;
  logic        clr;
  logic        locked;
  logic        err;
  logic        err_seen;
  logic [31:0] beats;
  logic [31:0] errors;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic err;
    logic locked;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] sw;

  axisprbscheck dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .i_hold        (hold),
    .i_clear       (clr),
    .o_locked      (locked),
    .o_err         (err),
    .o_err_seen    (err_seen),
    .o_beats       (beats),
    .o_errors      (errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRBS step, written from the tap positions (bits 14 and 1).
  function automatic logic [31:0] nxt(input logic [31:0] d);
    return {d[14] ^ d[1], d[31:1]};
  endfunction

  // Apply one cycle of stimulus and queue the expected post-edge o_err/o_locked.
  task automatic drive(input logic v, input logic [31:0] d, input logic h,
                       input logic c, input logic e_err, input logic e_lock);
    exp_t t;
    tvalid = v;
    tdata  = d;
    hold   = h;
    clr    = c;
    t.err    = e_err;
    t.locked = e_lock;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tvalid = 1'b1; tdata = 32'h8000_0000; hold = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({locked, err, err_seen, tready} !== 4'b0000 || beats !== 32'd0 || errors !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: locked/err/seen/tready=%b%b%b%b beats=%0d errors=%0d required all 0",
               locked, err, err_seen, tready, beats, errors);
    end
    rst = 1'b0;
    tvalid = 1'b0;
  endtask

  task automatic test_clean();
    sw = 32'h8000_0000;
    for (int i = 0; i < 105; i++) begin
      drive(1'b1, sw, 1'b0, 1'b0, 1'b0, (i >= 4));
      sw = nxt(sw);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL clean beat %0d: err/locked=%b%b required %b%b", i, err, locked, e.err, e.locked);
      end
    end
    n_vec++;
    if (beats !== 32'd100 || errors !== 32'd0 || err_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL clean counters: beats=%0d errors=%0d seen=%b required 100 0 0", beats, errors, err_seen);
    end
  endtask

  task automatic test_bitflip();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0) ? (sw ^ 32'h0000_0001) : sw, 1'b0, 1'b0, (i == 0), 1'b1);
      sw = nxt(sw);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL bitflip beat %0d: err/locked=%b%b required %b%b", i, err, locked, e.err, e.locked);
      end
    end
    n_vec++;
    if (errors !== 32'd1 || err_seen !== 1'b1 || beats !== 32'd106) begin
      n_bad++;
      $display("FAIL bitflip counters: errors=%0d seen=%b beats=%0d required 1 1 106", errors, err_seen, beats);
    end
  endtask

  task automatic test_jump();
    drive(1'b0, sw, 1'b0, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    n_vec++;
    if (errors !== 32'd0 || beats !== 32'd0 || err_seen !== 1'b0 || locked !== e.locked) begin
      n_bad++;
      $display("FAIL jump clear: errors=%0d beats=%0d seen=%b locked=%b required 0 0 0 1",
               errors, beats, err_seen, locked);
    end
    sw = 32'h1234_5678;
    for (int j = 0; j < 13; j++) begin
      // 8 errors unlock; then 1 seed beat plus 4 matching beats relock.
      drive(1'b1, sw, 1'b0, 1'b0, (j < 8), (j < 7) || (j >= 12));
      sw = nxt(sw);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL jump beat %0d: err/locked=%b%b required %b%b", j, err, locked, e.err, e.locked);
      end
    end
    n_vec++;
    if (errors !== 32'd8 || beats !== 32'd8) begin
      n_bad++;
      $display("FAIL jump counters: errors=%0d beats=%0d required 8 8", errors, beats);
    end
  endtask

  task automatic test_search_garbage();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i < 10) ? 32'h0 : 32'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL garbage beat %0d: err/locked=%b%b required %b%b", i, err, locked, e.err, e.locked);
      end
    end
    n_vec++;
    if (beats !== 32'd0 || errors !== 32'd0 || err_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL garbage counters: beats=%0d errors=%0d seen=%b required 0 0 0", beats, errors, err_seen);
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    logic h;
    acc = 0;
    sw  = 32'h8000_0000;
    for (int i = 0; i < 200; i++) begin
      h = ($urandom_range(0, 2) == 0);
      hold = h;
      tvalid = 1'b1;
      tdata = sw;
      #1;
      n_vec++;
      if (tready !== !h) begin
        n_bad++;
        $display("FAIL tready cycle %0d: tready=%b required %b", i, tready, !h);
      end
      if (!h) acc++;
      drive(1'b1, sw, h, 1'b0, 1'b0, (acc >= 5));
      if (!h) sw = nxt(sw);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL backpressure cycle %0d: err/locked=%b%b required %b%b", i, err, locked, e.err, e.locked);
      end
    end
    n_vec++;
    if (beats !== 32'(acc - 5) || errors !== 32'd0) begin
      n_bad++;
      $display("FAIL backpressure counters: beats=%0d errors=%0d required %0d 0", beats, errors, acc - 5);
    end
  endtask

  task automatic test_clear_reset();
    drive(1'b1, sw ^ 32'hFF00_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    sw = nxt(sw);
    e = sb.pop_front();
    n_vec++;
    if (err !== e.err || locked !== e.locked || errors !== 32'd0 || err_seen !== 1'b0 || beats !== 32'd0) begin
      n_bad++;
      $display("FAIL clear+error: err=%b locked=%b errors=%0d seen=%b beats=%0d required 1 1 0 0 0",
               err, locked, errors, err_seen, beats);
    end
    drive(1'b1, sw, 1'b0, 1'b0, 1'b0, 1'b1);
    sw = nxt(sw);
    e = sb.pop_front();
    n_vec++;
    if (err !== e.err || locked !== e.locked || beats !== 32'd1) begin
      n_bad++;
      $display("FAIL after clear: err=%b locked=%b beats=%0d required 0 1 1", err, locked, beats);
    end
    rst = 1'b1;
    tvalid = 1'b1;
    tdata = sw;
    @(posedge clk);
    #1;
    n_vec++;
    if ({locked, err, err_seen, tready} !== 4'b0000 || beats !== 32'd0 || errors !== 32'd0) begin
      n_bad++;
      $display("FAIL mid-lock reset: locked/err/seen/tready=%b%b%b%b beats=%0d errors=%0d required all 0",
               locked, err, err_seen, tready, beats, errors);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, sw, 1'b0, 1'b0, 1'b0, (i >= 4));
      sw = nxt(sw);
      e = sb.pop_front();
      n_vec++;
      if (err !== e.err || locked !== e.locked) begin
        n_bad++;
        $display("FAIL relock beat %0d: err/locked=%b%b required %b%b", i, err, locked, e.err, e.locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bitflip();
    test_jump();
    test_search_garbage();
    test_backpressure();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
